// File: rtl/plic_regfile_param_if.sv
// Register bus between a requester and the PLIC register file.
// The requester holds req.valid until resp.ready and drops it in that same cycle.
interface plic_regfile_param_if;
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic        valid;
  } req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } resp_t;

  req_t  req;
  resp_t resp;

  modport master (output req, input  resp);
  modport slave  (input  req, output resp);
endinterface

// File: rtl/plic_regfile_param.sv
// PLIC priority/enable/threshold/claim-complete register file on a register bus.
// Two cycles per access: decode in IDLE, a one-cycle registered response in RESP; requests are ignored during RESP.
module plic_regfile_param #(
  parameter int unsigned NumSrc   = 32,
  parameter int unsigned NumTgt   = 4,
  parameter int unsigned PrioW    = 3,
  parameter logic [31:0] BaseAddr = 32'hc000000,
  localparam int unsigned IdW     = $clog2(NumSrc + 1),
  localparam int unsigned NumWd   = (NumSrc + 31) / 32
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  plic_regfile_param_if.slave              reg_bus,
  input  logic [NumSrc-1:0]                ip_i,
  input  logic [NumTgt-1:0][IdW-1:0]       claim_id_i,
  output logic [NumSrc-1:0][PrioW-1:0]     prio_o,
  output logic [NumTgt-1:0][NumSrc-1:0]    ie_o,
  output logic [NumTgt-1:0][PrioW-1:0]     threshold_o,
  output logic [NumTgt-1:0]                claim_o,
  output logic [NumTgt-1:0][IdW-1:0]       claim_id_o,
  output logic [NumTgt-1:0]                complete_o,
  output logic [NumTgt-1:0][IdW-1:0]       complete_id_o
);

  typedef enum logic {IDLE, RESP} state_e;
  typedef enum logic [2:0] {K_NONE, K_PRIO, K_IP, K_IE, K_THR, K_CC} kind_e;

  state_e                          state_q, state_d;
  logic [31:0]                     rdata_q, rdata_d;
  logic                            error_q, error_d;
  logic [NumSrc-1:0][PrioW-1:0]    prio_q, prio_d;
  logic [NumTgt-1:0][NumSrc-1:0]   ie_q, ie_d;
  logic [NumTgt-1:0][PrioW-1:0]    thr_q, thr_d;
  logic [NumTgt-1:0]               claim_q, claim_d;
  logic [NumTgt-1:0][IdW-1:0]      claim_id_q, claim_id_d;
  logic [NumTgt-1:0]               complete_q, complete_d;
  logic [NumTgt-1:0][IdW-1:0]      complete_id_q, complete_id_d;

  logic [31:0]    off;
  logic [31:0]    idx;
  logic [31:0]    tgt;
  kind_e          kind;
  logic           in_range;
  logic           wr;
  logic [IdW-1:0] wid;

  assign wr  = reg_bus.req.write;
  assign wid = reg_bus.req.wdata[IdW-1:0];

  // Address decode: region kind, word/source index, target index, legality.
  always_comb begin
    off      = reg_bus.req.addr - BaseAddr;
    idx      = '0;
    tgt      = '0;
    kind     = K_NONE;
    in_range = 1'b0;
    if (reg_bus.req.addr[1:0] == 2'b00 && reg_bus.req.addr >= BaseAddr) begin
      if (off < 32'h1000) begin
        kind     = K_PRIO;
        idx      = {2'b00, off[31:2]};
        in_range = idx < NumSrc;
      end else if (off < 32'h2000) begin
        kind     = K_IP;
        idx      = (off - 32'h1000) >> 2;
        in_range = (idx < NumWd) && !wr;
      end else if (off < 32'h20_0000) begin
        kind     = K_IE;
        tgt      = (off - 32'h2000) >> 7;
        idx      = {27'd0, off[6:2]};
        in_range = (tgt < NumTgt) && (idx < NumWd);
      end else begin
        tgt      = (off - 32'h20_0000) >> 12;
        in_range = tgt < NumTgt;
        if (off[11:0] == 12'h000) begin
          kind = K_THR;
        end else if (off[11:0] == 12'h004) begin
          kind = K_CC;
        end else begin
          in_range = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rdata_d       = '0;
    error_d       = 1'b0;
    prio_d        = prio_q;
    ie_d          = ie_q;
    thr_d         = thr_q;
    claim_d       = '0;
    claim_id_d    = claim_id_q;
    complete_d    = '0;
    complete_id_d = complete_id_q;
    case (state_q)
      IDLE: begin
        if (reg_bus.req.valid) begin
          state_d = RESP;
          if (!in_range) begin
            error_d = 1'b1;
          end else begin
            case (kind)
              K_PRIO: begin
                for (int unsigned i = 0; i < NumSrc; i++) begin
                  if (idx == 32'(i)) begin
                    if (wr) prio_d[i] = reg_bus.req.wdata[PrioW-1:0];
                    else    rdata_d   = 32'(prio_q[i]);
                  end
                end
              end
              K_IP: begin
                for (int unsigned i = 0; i < NumSrc; i++) begin
                  if (idx == 32'(i / 32)) rdata_d[i % 32] = ip_i[i];
                end
              end
              K_IE: begin
                // Bits past NumSrc in the last word have no storage, so they drop on write and read as 0.
                for (int unsigned t = 0; t < NumTgt; t++) begin
                  for (int unsigned i = 0; i < NumSrc; i++) begin
                    if (tgt == 32'(t) && idx == 32'(i / 32)) begin
                      if (wr) ie_d[t][i]      = reg_bus.req.wdata[i % 32];
                      else    rdata_d[i % 32] = ie_q[t][i];
                    end
                  end
                end
              end
              K_THR: begin
                for (int unsigned t = 0; t < NumTgt; t++) begin
                  if (tgt == 32'(t)) begin
                    if (wr) thr_d[t] = reg_bus.req.wdata[PrioW-1:0];
                    else    rdata_d  = 32'(thr_q[t]);
                  end
                end
              end
              K_CC: begin
                for (int unsigned t = 0; t < NumTgt; t++) begin
                  if (tgt == 32'(t)) begin
                    if (wr) begin
                      if (wid != '0 && 32'(wid) <= NumSrc) begin
                        complete_d[t]    = 1'b1;
                        complete_id_d[t] = wid;
                      end
                    end else begin
                      rdata_d = 32'(claim_id_i[t]);
                      if (claim_id_i[t] != '0) begin
                        claim_d[t]    = 1'b1;
                        claim_id_d[t] = claim_id_i[t];
                      end
                    end
                  end
                end
              end
              default: error_d = 1'b1;
            endcase
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      rdata_q       <= '0;
      error_q       <= 1'b0;
      prio_q        <= '0;
      ie_q          <= '0;
      thr_q         <= '0;
      claim_q       <= '0;
      claim_id_q    <= '0;
      complete_q    <= '0;
      complete_id_q <= '0;
    end else begin
      state_q       <= state_d;
      rdata_q       <= rdata_d;
      error_q       <= error_d;
      prio_q        <= prio_d;
      ie_q          <= ie_d;
      thr_q         <= thr_d;
      claim_q       <= claim_d;
      claim_id_q    <= claim_id_d;
      complete_q    <= complete_d;
      complete_id_q <= complete_id_d;
    end
  end

  // A response or pulse already in flight when reset rises is suppressed immediately.
  assign reg_bus.resp = {(rst_i ? 32'd0 : rdata_q),
                         error_q & ~rst_i,
                         (state_q == RESP) & ~rst_i};

  assign claim_o       = claim_q & {NumTgt{~rst_i}};
  assign complete_o    = complete_q & {NumTgt{~rst_i}};
  assign claim_id_o    = claim_id_q;
  assign complete_id_o = complete_id_q;
  assign prio_o        = prio_q;
  assign ie_o          = ie_q;
  assign threshold_o   = thr_q;

endmodule

// File: tb/tb_plic_regfile_param.sv
// Bench for plic_regfile_param: directed accesses push expected responses; a negedge monitor pops and compares.
module tb_plic_regfile_param;
  localparam int unsigned NumSrc = 32;
  localparam int unsigned NumTgt = 4;
  localparam int unsigned PrioW  = 3;
  localparam int unsigned IdW    = 6;
  localparam logic [31:0] Base   = 32'hc000000;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  logic [NumSrc-1:0]             ip_i = '0;
  logic [NumTgt-1:0][IdW-1:0]    claim_id_i = '0;
  logic [NumSrc-1:0][PrioW-1:0]  prio_o;
  logic [NumTgt-1:0][NumSrc-1:0] ie_o;
  logic [NumTgt-1:0][PrioW-1:0]  threshold_o;
  logic [NumTgt-1:0]             claim_o;
  logic [NumTgt-1:0][IdW-1:0]    claim_id_o;
  logic [NumTgt-1:0]             complete_o;
  logic [NumTgt-1:0][IdW-1:0]    complete_id_o;

  plic_regfile_param_if bus ();

  plic_regfile_param #(
    .NumSrc(NumSrc), .NumTgt(NumTgt), .PrioW(PrioW), .BaseAddr(Base)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .reg_bus(bus),
    .ip_i(ip_i), .claim_id_i(claim_id_i),
    .prio_o(prio_o), .ie_o(ie_o), .threshold_o(threshold_o),
    .claim_o(claim_o), .claim_id_o(claim_id_o),
    .complete_o(complete_o), .complete_id_o(complete_id_o)
  );

  typedef struct {
    logic [31:0]       rdata;
    logic              error;
    logic [NumTgt-1:0] claim;
    logic [NumTgt-1:0] complete;
    logic [IdW-1:0]    id;
    string             nm;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  logic mon_en   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (mon_en) begin
      if (bus.resp.ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_ready", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk({mon_e.nm, "_rdata"},    bus.resp.rdata,      mon_e.rdata);
          chk({mon_e.nm, "_error"},    32'(bus.resp.error), 32'(mon_e.error));
          chk({mon_e.nm, "_claim"},    32'(claim_o),        32'(mon_e.claim));
          chk({mon_e.nm, "_complete"}, 32'(complete_o),     32'(mon_e.complete));
          for (int t = 0; t < NumTgt; t++) begin
            if (mon_e.claim[t])    chk({mon_e.nm, "_claim_id"},    32'(claim_id_o[t]),    32'(mon_e.id));
            if (mon_e.complete[t]) chk({mon_e.nm, "_complete_id"}, 32'(complete_id_o[t]), 32'(mon_e.id));
          end
        end
      end else begin
        chk("idle_pulses", 32'({claim_o, complete_o}), 32'd0);
      end
    end
  end

  task automatic acc(input logic [31:0] a, input logic w, input logic [31:0] wd,
                     input logic [31:0] rd, input logic er,
                     input logic [NumTgt-1:0] cl, input logic [NumTgt-1:0] cp,
                     input logic [IdW-1:0] id, input string nm);
    exp_t e;
    int   n;
    e.rdata = rd; e.error = er; e.claim = cl; e.complete = cp; e.id = id; e.nm = nm;
    sb.push_back(e);
    @(negedge clk_i);
    bus.req.addr  = a;
    bus.req.write = w;
    bus.req.wdata = wd;
    bus.req.valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!bus.resp.ready && n < 4);
    bus.req.valid = 1'b0;
    chk({nm, "_latency"}, 32'(n), 32'd1);
  endtask

  initial begin
    bus.req.addr  = '0;
    bus.req.write = 1'b0;
    bus.req.wdata = '0;
    bus.req.valid = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_ready", 32'(bus.resp.ready), 32'd0);
    chk("rst_error", 32'(bus.resp.error), 32'd0);
    chk("rst_rdata", bus.resp.rdata, 32'd0);
    chk("rst_pulses", 32'({claim_o, complete_o}), 32'd0);
    chk("rst_prio", 32'(prio_o != '0), 32'd0);
    chk("rst_ie", 32'(ie_o != '0), 32'd0);
    chk("rst_thr", 32'(threshold_o), 32'd0);
    mon_en = 1'b1;

    acc(Base + 32'h14,     1'b0, 32'd0, 32'd0, 1'b0, 4'b0, 4'b0, 6'd0, "rd_prio5");
    acc(Base + 32'h2180,   1'b0, 32'd0, 32'd0, 1'b0, 4'b0, 4'b0, 6'd0, "rd_ie3");
    acc(Base + 32'h202000, 1'b0, 32'd0, 32'd0, 1'b0, 4'b0, 4'b0, 6'd0, "rd_thr2");

    acc(Base + 32'h1C, 1'b1, 32'hFFFF_FFFD, 32'd0, 1'b0, 4'b0, 4'b0, 6'd0, "wr_prio7");
    chk("prio7_resp_cycle", 32'(prio_o[7]), 32'd5);
    acc(Base + 32'h1C, 1'b0, 32'd0, 32'd5, 1'b0, 4'b0, 4'b0, 6'd0, "rd_prio7");

    acc(Base + 32'h2100, 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b0, 4'b0, 4'b0, 6'd0, "wr_ie2");
    chk("ie2_value", ie_o[2], 32'hFFFF_FFFF);
    acc(Base + 32'h2100, 1'b0, 32'd0, 32'hFFFF_FFFF, 1'b0, 4'b0, 4'b0, 6'd0, "rd_ie2");
    acc(Base + 32'h200000, 1'b1, 32'h0000_000A, 32'd0, 1'b0, 4'b0, 4'b0, 6'd0, "wr_thr0");
    chk("thr0_value", 32'(threshold_o[0]), 32'd2);
    acc(Base + 32'h200000, 1'b0, 32'd0, 32'd2, 1'b0, 4'b0, 4'b0, 6'd0, "rd_thr0");
    ip_i = 32'hDEAD_BEEF;
    acc(Base + 32'h1000, 1'b0, 32'd0, 32'hDEAD_BEEF, 1'b0, 4'b0, 4'b0, 6'd0, "rd_ip0");

    claim_id_i[1] = 6'd9;
    acc(Base + 32'h201004, 1'b0, 32'd0, 32'd9, 1'b0, 4'b0010, 4'b0, 6'd9, "cc1_claim9");
    claim_id_i[1] = 6'd0;
    acc(Base + 32'h201004, 1'b0, 32'd0, 32'd0, 1'b0, 4'b0, 4'b0, 6'd0, "cc1_claim0");

    acc(Base + 32'h203004, 1'b1, 32'd9,  32'd0, 1'b0, 4'b0, 4'b1000, 6'd9,  "cc3_cmp9");
    acc(Base + 32'h203004, 1'b1, 32'd0,  32'd0, 1'b0, 4'b0, 4'b0,    6'd0,  "cc3_cmp0");
    acc(Base + 32'h203004, 1'b1, 32'd33, 32'd0, 1'b0, 4'b0, 4'b0,    6'd0,  "cc3_cmp33");
    acc(Base + 32'h203004, 1'b1, 32'd32, 32'd0, 1'b0, 4'b0, 4'b1000, 6'd32, "cc3_cmp32");
    acc(Base + 32'h203004, 1'b1, 32'h45, 32'd0, 1'b0, 4'b0, 4'b1000, 6'd5,  "cc3_cmp_hibits");

    acc(Base + 32'h1000,   1'b1, 32'd1,   32'd0, 1'b1, 4'b0, 4'b0, 6'd0, "wr_ip_err");
    acc(Base + 32'h2,      1'b0, 32'd0,   32'd0, 1'b1, 4'b0, 4'b0, 6'd0, "misalign_err");
    acc(Base + 32'hFFC,    1'b0, 32'd0,   32'd0, 1'b1, 4'b0, 4'b0, 6'd0, "prio1023_err");
    acc(Base + 32'h80,     1'b1, 32'd7,   32'd0, 1'b1, 4'b0, 4'b0, 6'd0, "wr_prio32_err");
    acc(Base + 32'h2004,   1'b0, 32'd0,   32'd0, 1'b1, 4'b0, 4'b0, 6'd0, "ie_word1_err");
    acc(Base + 32'h2200,   1'b1, 32'd1,   32'd0, 1'b1, 4'b0, 4'b0, 6'd0, "ie_tgt4_err");
    acc(Base + 32'h204000, 1'b1, 32'd1,   32'd0, 1'b1, 4'b0, 4'b0, 6'd0, "thr_tgt4_err");
    acc(Base + 32'h200008, 1'b0, 32'd0,   32'd0, 1'b1, 4'b0, 4'b0, 6'd0, "hole_err");
    acc(32'h0000_0000,     1'b0, 32'd0,   32'd0, 1'b1, 4'b0, 4'b0, 6'd0, "below_base_err");
    chk("err_prio7_kept", 32'(prio_o[7]), 32'd5);
    chk("err_ie2_kept", ie_o[2], 32'hFFFF_FFFF);
    chk("err_thr_kept", 32'(threshold_o), 32'd2);

    claim_id_i[2] = 6'd5;
    @(negedge clk_i);
    bus.req.addr  = Base + 32'h202004;
    bus.req.write = 1'b0;
    bus.req.wdata = '0;
    bus.req.valid = 1'b1;
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    bus.req.valid = 1'b0;
    @(negedge clk_i);
    chk("midrst_ready", 32'(bus.resp.ready), 32'd0);
    chk("midrst_claim", 32'(claim_o), 32'd0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("midrst_prio7", 32'(prio_o[7]), 32'd0);
    chk("midrst_ie2", ie_o[2], 32'd0);
    chk("midrst_thr0", 32'(threshold_o[0]), 32'd0);
    acc(Base + 32'h1C, 1'b0, 32'd0, 32'd0, 1'b0, 4'b0, 4'b0, 6'd0, "post_rst_prio7");

    repeat (3) @(negedge clk_i);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
